// File: rtl/mem_port_arbiter.sv
// Round-robin share of one single-port data memory between fetch and load/store ports, with LSU lane alignment.
// Latency 1 cycle grant-to-response; no backpressure on responses, requests simply wait (held) until granted.
module mem_port_arbiter #(
    parameter  int N  = 32,
    localparam int AW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_if_req,
    input  logic [31:0]   i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [31:0]   o_if_rdata,
    output logic          o_if_err,
    input  logic          i_ls_req,
    input  logic          i_ls_we,
    input  logic [31:0]   i_ls_addr,
    input  logic [1:0]    i_ls_size,
    input  logic          i_ls_unsigned,
    input  logic [31:0]   i_ls_wdata,
    output logic          o_ls_gnt,
    output logic          o_ls_rvalid,
    output logic [31:0]   o_ls_rdata,
    output logic          o_ls_err,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [3:0]    o_mem_bmask,
    output logic          o_mem_wren,
    input  logic [31:0]   i_mem_rdata
);

    localparam logic [31:0] MEM_BYTES = 32'(4 * N);
    localparam logic        RR_IF     = 1'b0;
    localparam logic        RR_LS     = 1'b1;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    logic        rr_last;
    logic        if_gnt, ls_gnt;
    logic        if_err_c, ls_err_c;
    logic [1:0]  ls_off;
    logic [3:0]  base_mask;
    logic [31:0] lane_wdata;
    logic [31:0] ls_word_shift;
    logic [31:0] ls_load_dat;
    rsp_t        if_rsp, ls_rsp;

    assign ls_off   = i_ls_addr[1:0];
    assign if_err_c = (i_if_addr[1:0] != 2'b00) || (i_if_addr >= MEM_BYTES);

    always_comb begin
        ls_err_c = (i_ls_addr >= MEM_BYTES);
        case (i_ls_size)
            2'b00:   ls_err_c = ls_err_c;
            2'b01:   ls_err_c = ls_err_c || i_ls_addr[0];
            2'b10:   ls_err_c = ls_err_c || (ls_off != 2'b00);
            default: ls_err_c = 1'b1;
        endcase
    end

    // Grants are suppressed while reset is held so nothing reaches the memory.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (i_reset) begin
            if (i_if_req && (!i_ls_req || rr_last == RR_LS)) begin
                if_gnt = 1'b1;
            end else if (i_ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        base_mask  = 4'b0000;
        lane_wdata = i_ls_wdata;
        case (i_ls_size)
            2'b00: begin
                base_mask  = 4'b0001 << ls_off;
                lane_wdata = {4{i_ls_wdata[7:0]}};
            end
            2'b01: begin
                base_mask  = 4'b0011 << ls_off;
                lane_wdata = {2{i_ls_wdata[15:0]}};
            end
            2'b10:   base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
    end

    assign o_if_gnt    = if_gnt;
    assign o_ls_gnt    = ls_gnt;
    assign o_mem_wren  = ls_gnt && i_ls_we && !ls_err_c;
    assign o_mem_bmask = o_mem_wren ? base_mask : 4'b0000;
    assign o_mem_wdata = o_mem_wren ? lane_wdata : 32'h0;
    assign o_mem_addr  = ls_gnt ? i_ls_addr[AW+1:2] :
                         (if_gnt ? i_if_addr[AW+1:2] : '0);

    assign ls_word_shift = i_mem_rdata >> {ls_off, 3'b000};

    always_comb begin
        case (i_ls_size)
            2'b00:   ls_load_dat = i_ls_unsigned ? {24'h0, ls_word_shift[7:0]}
                                                 : {{24{ls_word_shift[7]}}, ls_word_shift[7:0]};
            2'b01:   ls_load_dat = i_ls_unsigned ? {16'h0, ls_word_shift[15:0]}
                                                 : {{16{ls_word_shift[15]}}, ls_word_shift[15:0]};
            default: ls_load_dat = ls_word_shift;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rr_last <= RR_LS;
            if_rsp  <= '0;
            ls_rsp  <= '0;
        end else begin
            if (if_gnt) begin
                rr_last <= RR_IF;
            end else if (ls_gnt) begin
                rr_last <= RR_LS;
            end
            if_rsp.vld <= if_gnt;
            if_rsp.err <= if_gnt && if_err_c;
            if_rsp.dat <= (if_gnt && !if_err_c) ? i_mem_rdata : 32'h0;
            ls_rsp.vld <= ls_gnt;
            ls_rsp.err <= ls_gnt && ls_err_c;
            ls_rsp.dat <= (ls_gnt && !ls_err_c && !i_ls_we) ? ls_load_dat : 32'h0;
        end
    end

    assign o_if_rvalid = if_rsp.vld;
    assign o_if_err    = if_rsp.err;
    assign o_if_rdata  = if_rsp.dat;
    assign o_ls_rvalid = ls_rsp.vld;
    assign o_ls_err    = ls_rsp.err;
    assign o_ls_rdata  = ls_rsp.dat;

endmodule
